// File: rtl/mem_wb_cycle.sv
// mem_wb_cycle: data memory access in M plus the M/W pipeline register and writeback mux.
// Optional DMEM_RANGE_CHECK_EN drops out-of-range accesses and raises a sticky MemErrW.
module mem_wb_cycle #(
  parameter int DMEM_DEPTH = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        RegWriteM,
  input  logic        MemWriteM,
  input  logic        ResultSrcM,
  input  logic [4:0]  RD_M,
  input  logic [31:0] ALU_ResultM,
  input  logic [31:0] WriteDataM,
  input  logic        StallW,
  input  logic        FlushW,
  output logic        RegWriteW,
  output logic [4:0]  RDW,
  output logic [31:0] ResultW,
  output logic        MemErrW
);
  localparam int AW = $clog2(DMEM_DEPTH);
  logic [31:0] mem [DMEM_DEPTH];
  logic [AW-1:0] idx;
  logic [31:0] read_data;
  logic store;
  logic ResultSrcW;
  logic [31:0] ALUResultW, ReadDataW;
  assign idx = ALU_ResultM[AW+1:2];
`ifdef DMEM_RANGE_CHECK_EN
  logic oor;
  assign oor = |ALU_ResultM[31:AW+2];
  assign store = MemWriteM & ~oor;
  assign read_data = oor ? 32'h0 : mem[idx];
  always_ff @(posedge clk or negedge rst)
    if (!rst) MemErrW <= 1'b0;
    else if (oor & (MemWriteM | ResultSrcM)) MemErrW <= 1'b1;
`else
  assign store = MemWriteM;
  assign read_data = mem[idx];
  assign MemErrW = 1'b0;
`endif
  // Memory is not reset; sampling rst here aborts a store whose edge falls inside reset.
  always_ff @(posedge clk)
    if (rst && store) mem[idx] <= WriteDataM;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      RegWriteW  <= 1'b0;
      RDW        <= 5'd0;
      ResultSrcW <= 1'b0;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
    end else if (FlushW) begin
      RegWriteW  <= 1'b0;
      RDW        <= 5'd0;
      ResultSrcW <= 1'b0;
      ALUResultW <= 32'h0;
      ReadDataW  <= 32'h0;
    end else if (!StallW) begin
      RegWriteW  <= RegWriteM;
      RDW        <= RD_M;
      ResultSrcW <= ResultSrcM;
      ALUResultW <= ALU_ResultM;
      ReadDataW  <= read_data;
    end
  assign ResultW = ResultSrcW ? ReadDataW : ALUResultW;
endmodule

// File: tb/tb_mem_wb_cycle.sv
// tb_mem_wb_cycle: directed self-checking bench for mem_wb_cycle.
module tb_mem_wb_cycle;
  logic clk = 1'b0, rst = 1'b0;
  logic RegWriteM = 0, MemWriteM = 0, ResultSrcM = 0, StallW = 0, FlushW = 0;
  logic [4:0] RD_M = 0;
  logic [31:0] ALU_ResultM = 0, WriteDataM = 0;
  logic RegWriteW, MemErrW;
  logic [4:0] RDW;
  logic [31:0] ResultW;
  int checks = 0, errors = 0;
  always #5 clk = ~clk;
  mem_wb_cycle #(.DMEM_DEPTH(256)) dut (
    .clk(clk), .rst(rst), .RegWriteM(RegWriteM), .MemWriteM(MemWriteM),
    .ResultSrcM(ResultSrcM), .RD_M(RD_M), .ALU_ResultM(ALU_ResultM),
    .WriteDataM(WriteDataM), .StallW(StallW), .FlushW(FlushW),
    .RegWriteW(RegWriteW), .RDW(RDW), .ResultW(ResultW), .MemErrW(MemErrW)
  );
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic drive(input logic rw, input logic mw, input logic rs, input logic [4:0] rd,
                       input logic [31:0] alu, input logic [31:0] wd);
    @(negedge clk);
    RegWriteM = rw; MemWriteM = mw; ResultSrcM = rs; RD_M = rd; ALU_ResultM = alu; WriteDataM = wd;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic check_w(input string tag, input logic rw, input logic [4:0] rd, input logic [31:0] res);
    check({tag, "_regwrite"}, {31'h0, RegWriteW}, {31'h0, rw});
    check({tag, "_rd"}, {27'h0, RDW}, {27'h0, rd});
    check({tag, "_result"}, ResultW, res);
  endtask
  initial begin
    #2;
    check_w("reset", 1'b0, 5'd0, 32'h0);
    check("reset_memerr", {31'h0, MemErrW}, 32'h0);
    drive(0, 1, 0, 5'd0, 32'h10, 32'h0000000A);
    rst = 1'b1;
    step();
    check_w("store_alu", 1'b0, 5'd0, 32'h10);
    drive(1, 0, 1, 5'd2, 32'h10, 32'h0);
    step();
    check_w("load_after_store", 1'b1, 5'd2, 32'h0000000A);
    drive(1, 0, 1, 5'd1, 32'h13, 32'h0);
    step();
    check("low_bits_ignored", ResultW, 32'h0000000A);
    drive(1, 0, 0, 5'd3, 32'h3, 32'h0);
    step();
    check_w("alu_op", 1'b1, 5'd3, 32'h3);
    drive(1, 1, 0, 5'd7, 32'h18, 32'h0000BEEF);
    StallW = 1'b1;
    step();
    check_w("stall1", 1'b1, 5'd3, 32'h3);
    drive(0, 0, 1, 5'd9, 32'h99, 32'h0);
    step();
    check_w("stall2", 1'b1, 5'd3, 32'h3);
    drive(1, 0, 1, 5'd4, 32'h18, 32'h0);
    StallW = 1'b0;
    step();
    check_w("store_during_stall", 1'b1, 5'd4, 32'h0000BEEF);
    drive(1, 0, 0, 5'd0, 32'h55, 32'h0);
    step();
    check_w("x0_pass", 1'b1, 5'd0, 32'h55);
    drive(1, 0, 0, 5'd6, 32'h66, 32'h0);
    FlushW = 1'b1;
    StallW = 1'b1;
    step();
    check_w("flush_over_stall", 1'b0, 5'd0, 32'h0);
    drive(1, 0, 0, 5'd8, 32'h44, 32'h0);
    FlushW = 1'b0;
    StallW = 1'b0;
    step();
    check_w("pre_reset", 1'b1, 5'd8, 32'h44);
    drive(1, 1, 0, 5'd8, 32'h10, 32'h0000DEAD);
    #2 rst = 1'b0;
    #1;
    check_w("async_reset", 1'b0, 5'd0, 32'h0);
    step();
    check_w("in_reset", 1'b0, 5'd0, 32'h0);
    drive(1, 0, 1, 5'd2, 32'h10, 32'h0);
    rst = 1'b1;
    step();
    check_w("store_aborted", 1'b1, 5'd2, 32'h0000000A);
    drive(0, 1, 0, 5'd0, 32'h0, 32'h00000011);
    step();
    drive(0, 1, 0, 5'd0, 32'h3FC, 32'h00000077);
    step();
    check("top_word_nomemerr", {31'h0, MemErrW}, 32'h0);
    drive(1, 0, 1, 5'd5, 32'h3FC, 32'h0);
    step();
    check("top_word_load", ResultW, 32'h77);
    drive(0, 1, 0, 5'd0, 32'h400, 32'h00000055);
    step();
`ifdef DMEM_RANGE_CHECK_EN
    check("oor_store_memerr", {31'h0, MemErrW}, 32'h1);
`else
    check("wrap_store_memerr", {31'h0, MemErrW}, 32'h0);
`endif
    drive(1, 0, 1, 5'd6, 32'h0, 32'h0);
    step();
`ifdef DMEM_RANGE_CHECK_EN
    check("word0_after_oor", ResultW, 32'h11);
    check("memerr_sticky", {31'h0, MemErrW}, 32'h1);
`else
    check("word0_after_wrap", ResultW, 32'h55);
    check("memerr_tied", {31'h0, MemErrW}, 32'h0);
`endif
    drive(1, 0, 1, 5'd6, 32'h400, 32'h0);
    step();
`ifdef DMEM_RANGE_CHECK_EN
    check("oor_load", ResultW, 32'h0);
`else
    check("wrap_load", ResultW, 32'h55);
`endif
    drive(0, 0, 0, 5'd0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check("reset_clears_memerr", {31'h0, MemErrW}, 32'h0);
    rst = 1'b1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
